uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- Frame-sequencing controller for the UART receiver.
- Owns the oversampling edge/bit counters and the receive FSM (IDLE, START, DATA, PARITY, STOP, DONE).
- Issues one-cycle enable pulses to the sampler, deserializer and the start/parity/stop checkers, and consumes their registered error flags.
- Sits between the RX_IN pin logic and the receiver datapath; raises data_valid for each clean frame.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input and edge counter.

Ports:
- CLK  in  1  receiver oversampling clock; single clock domain.
- RST  in  1  synchronous reset, active-high.
- RX_IN  in  1  serial line, idle high.
- PAR_EN  in  1  parity bit present in frame.
- Prescale  in  PRESCALE_WIDTH  oversampling ratio; legal values are 8, 16 and 32.
- strt_glitch  in  1  registered start-check result; 1 means glitch.
- par_err  in  1  registered parity-check result.
- stp_err  in  1  registered stop-check result.
- edge_cnt  out  PRESCALE_WIDTH  current oversample edge within the bit.
- bit_cnt  out  4  current bit index in the frame; start bit is 0.
- dat_samp_en  out  1  sampler enable, level.
- deser_en  out  1  shift-in pulse.
- strt_chk_en  out  1  start-check pulse.
- par_chk_en  out  1  parity-check pulse.
- stp_chk_en  out  1  stop-check pulse.
- data_valid  out  1  one-cycle pulse for a good frame.
- busy  out  1  high in every state except IDLE.

Behaviour:

Definitions:
- P = Prescale, latched into p_q on the IDLE-to-START transition. PAR_EN is latched at the same time (par_q).
- LAST = p_q-1. CHK = p_q/2+2.
- The sampler takes its majority vote at edges p_q/2-1, p_q/2 and p_q/2+1. Its result is stable at CHK.

Reset:
- RST=1 at a CLK edge forces state=IDLE, edge_cnt=0, bit_cnt=0, p_q=8 and par_q=0.
- All outputs are 0 on the following cycle. This applies regardless of the current state, including reset mid-frame.

Counters:
- edge_cnt increments each cycle while busy and wraps LAST→0.
- bit_cnt increments on that wrap.
- Both clear on entry to START.

dat_samp_en:
- Equals busy; it is a level, not a pulse.

Check pulses (each one cycle, when edge_cnt==CHK):
- strt_chk_en in START.
- deser_en in DATA.
- par_chk_en in PARITY.
- stp_chk_en in STOP.
- Checker flags are valid from CHK+1, so they are always valid by LAST. P≥8 guarantees CHK<LAST.

FSM transitions (each evaluated at edge_cnt==LAST unless noted):
- IDLE: RX_IN==0 → START. Otherwise remain.
- START: strt_glitch=1 → IDLE (frame dropped, no data_valid). Otherwise → DATA.
- DATA: when bit_cnt==DATA_WIDTH → PARITY if par_q, else STOP.
- PARITY: → STOP unconditionally. par_err is captured into a sticky frame_err bit.
- STOP: stp_err is ORed into frame_err; → DONE.
- DONE (one cycle): data_valid = ~frame_err. frame_err clears. Next state is START if RX_IN==0 (back-to-back frame; one-cycle start-bit skew is accepted), else IDLE.

Boundary conditions:
- Changes to Prescale or PAR_EN mid-frame are ignored; the latched values are used.
- RX_IN is not examined outside IDLE and DONE.
- data_valid never asserts for a dropped or errored frame.
- Illegal Prescale (<8) behaviour is undefined; the bench must not drive it.

Latency:
- data_valid is asserted exactly 1 cycle after the STOP-bit LAST edge.
- That is (2+DATA_WIDTH+par_q)·p_q+1 cycles after START entry.

Optional Feature:
- Macro: UART_RX_ERR_FLAGS_EN.
- When defined: adds outputs par_err_flag and stp_err_flag, 1 bit each.
  - Each pulses for one cycle in DONE when the corresponding error was captured for that frame.
  - Both reset to 0.
- When undefined: these ports do not exist, and errors only suppress data_valid.

Decomposition:
- Shared package uart_rx_pkg holds:
  - The state encoding typedef: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4, DONE=3'd5.
  - The DATA_WIDTH default.
  - Legal prescale constants 8, 16 and 32.
- One sub-module: uart_rx_edge_bit_counter.
  - Holds the edge/bit counters, the wrap logic and the LAST/CHK compare outputs.
  - Enable and clear are driven by the FSM.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0xA5, clean checker flags → deser_en pulses 8 times at edge 6; data_valid=1 exactly 81 cycles after START entry.
2. Prescale=16, PAR_EN=1, par_err=1 at the parity CHK → frame completes through STOP; data_valid stays 0 (par_err_flag=1 with UART_RX_ERR_FLAGS_EN).
3. Prescale=8, RX_IN low for 3 cycles, strt_glitch=1 at edge 7 → return to IDLE; busy=0, no deser_en, no data_valid.
4. Two frames back-to-back at Prescale=32, RX_IN=0 during DONE → DONE goes directly to START; two data_valid pulses 353 cycles apart.
5. RST=1 asserted in DATA with bit_cnt=4 → next cycle state=IDLE, edge_cnt=0, bit_cnt=0, all outputs 0; the following good frame is received normally.
6. Prescale changed 8→16 mid-frame → current frame keeps 8-edge bits; the next frame uses 16.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receiver frame controller:
//   - rx_state_e     : receive FSM state encoding
//   - DATA_WIDTH_DEF : default number of data bits per frame
//   - PRESCALE_8/16/32 : legal oversampling ratios
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  localparam int DATA_WIDTH_DEF = 8;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter
// Oversample edge counter and frame bit counter for the UART receiver.
// edge_cnt runs 0..prescale-1 while cnt_en is high; its wrap advances
// bit_cnt. cnt_clr (FSM-driven) zeroes both and takes priority over cnt_en.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   cnt_en             count enable (FSM busy)
//   cnt_clr            clear both counters
//   prescale           latched oversampling ratio
//   edge_cnt, bit_cnt  counter values
//   at_last            edge_cnt == prescale-1 (last edge of the bit)
//   at_chk             edge_cnt == prescale/2+2 (sampler result is stable)
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cnt_en,
  input  logic                      cnt_clr,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      at_last,
  output logic                      at_chk
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_reg;
  logic [3:0]                bit_cnt_reg;
  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic [PRESCALE_WIDTH-1:0] chk_edge;

  assign last_edge = prescale - PRESCALE_WIDTH'(1);
  assign chk_edge  = (prescale >> 1) + PRESCALE_WIDTH'(2);

  assign at_last = (edge_cnt_reg == last_edge);
  assign at_chk  = (edge_cnt_reg == chk_edge);

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (cnt_clr) begin
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (cnt_en) begin
      if (at_last) begin
        edge_cnt_reg <= '0;
        bit_cnt_reg  <= bit_cnt_reg + 4'd1;
      end else begin
        edge_cnt_reg <= edge_cnt_reg + PRESCALE_WIDTH'(1);
      end
    end
  end

  assign edge_cnt = edge_cnt_reg;
  assign bit_cnt  = bit_cnt_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Frame-sequencing controller for the UART receiver. Runs the receive FSM
// (IDLE, START, DATA, PARITY, STOP, DONE), owns the oversampling counters,
// issues one-cycle check/shift pulses at edge CHK = p/2+2 and raises
// data_valid in DONE for a frame with no captured parity/stop error.
// Optional build macro: UART_RX_ERR_FLAGS_EN adds par_err_flag/stp_err_flag.
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   RX_IN            serial line (idle high), examined only in IDLE and DONE
//   PAR_EN           parity bit present (latched at frame start)
//   Prescale         oversampling ratio 8/16/32 (latched at frame start)
//   strt_glitch, par_err, stp_err  registered checker results
//   edge_cnt, bit_cnt               counter values
//   dat_samp_en      sampler enable level (== busy)
//   deser_en, strt_chk_en, par_chk_en, stp_chk_en  one-cycle pulses
//   data_valid       one-cycle pulse for a good frame
//   busy             high outside IDLE
//   par_err_flag, stp_err_flag  (macro only) per-frame error pulses in DONE
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid,
  output logic                      busy
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic                      par_err_flag,
  output logic                      stp_err_flag
`endif
);

  rx_state_e                 state_reg, state_next;
  logic [PRESCALE_WIDTH-1:0] p_q_reg;
  logic                      par_q_reg;
  // Per-frame sticky error captures; their OR is the frame error.
  logic                      par_seen_reg;
  logic                      stp_seen_reg;

  logic cnt_en, cnt_clr;
  logic at_last, at_chk;

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_counter (
    .CLK      (CLK),
    .RST      (RST),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .prescale (p_q_reg),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .at_last  (at_last),
    .at_chk   (at_chk)
  );

  always_comb begin
    state_next  = state_reg;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    busy        = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (!RX_IN) state_next = START;
      end
      START: begin
        strt_chk_en = at_chk;
        if (at_last) state_next = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        deser_en = at_chk;
        // bit_cnt is 1..DATA_WIDTH across the data bits (start bit is 0).
        if (at_last && (bit_cnt == 4'(DATA_WIDTH)))
          state_next = par_q_reg ? PARITY : STOP;
      end
      PARITY: begin
        par_chk_en = at_chk;
        if (at_last) state_next = STOP;
      end
      STOP: begin
        stp_chk_en = at_chk;
        if (at_last) state_next = DONE;
      end
      DONE: begin
        data_valid = ~(par_seen_reg | stp_seen_reg);
        // A low line here is the next start bit, taken one cycle late.
        state_next = RX_IN ? IDLE : START;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dat_samp_en = busy;
  assign cnt_en      = busy;
  // Counters read zero throughout IDLE and restart from zero on every
  // START entry (from IDLE or straight from DONE).
  assign cnt_clr     = (state_next == IDLE) || (state_reg == IDLE) || (state_reg == DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      p_q_reg      <= PRESCALE_WIDTH'(PRESCALE_8);
      par_q_reg    <= 1'b0;
      par_seen_reg <= 1'b0;
      stp_seen_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Frame parameters are frozen only when leaving IDLE; a back-to-back
      // frame from DONE reuses the previous frame's settings.
      if ((state_reg == IDLE) && (state_next == START)) begin
        p_q_reg   <= Prescale;
        par_q_reg <= PAR_EN;
      end
      if (state_reg == DONE) begin
        par_seen_reg <= 1'b0;
        stp_seen_reg <= 1'b0;
      end else begin
        if ((state_reg == PARITY) && at_last && par_err) par_seen_reg <= 1'b1;
        if ((state_reg == STOP) && at_last && stp_err)   stp_seen_reg <= 1'b1;
      end
    end
  end

`ifdef UART_RX_ERR_FLAGS_EN
  assign par_err_flag = (state_reg == DONE) && par_seen_reg;
  assign stp_err_flag = (state_reg == DONE) && stp_seen_reg;
`endif

endmodule
